// File: rtl/ex_stage_reg.sv
// ex_stage_reg: ID/EX register with MEM/WB forwarding and load-use bubbles; in: ID operands/control, MEM/WB bypass; out: ALU operands/ctrl, store data, EX control, hazard, forward selects
module ex_stage_reg #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int CTRL_W = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic              id_valid_i,
  input  logic [DATA_W-1:0] id_rs_data_i,
  input  logic [DATA_W-1:0] id_rt_data_i,
  input  logic [DATA_W-1:0] id_imm_i,
  input  logic [REG_AW-1:0] id_rs_addr_i,
  input  logic [REG_AW-1:0] id_rt_addr_i,
  input  logic [REG_AW-1:0] id_rd_addr_i,
  input  logic [CTRL_W-1:0] id_alu_ctrl_i,
  input  logic              id_alu_src_i,
  input  logic              id_reg_dst_i,
  input  logic              id_reg_write_i,
  input  logic              id_mem_read_i,
  input  logic              id_mem_write_i,
  input  logic              id_mem_to_reg_i,
  input  logic              mem_reg_write_i,
  input  logic [REG_AW-1:0] mem_rd_addr_i,
  input  logic [DATA_W-1:0] mem_result_i,
  input  logic              wb_reg_write_i,
  input  logic [REG_AW-1:0] wb_rd_addr_i,
  input  logic [DATA_W-1:0] wb_result_i,
  output logic [DATA_W-1:0] alu_src1_o,
  output logic [DATA_W-1:0] alu_src2_o,
  output logic [CTRL_W-1:0] alu_ctrl_o,
  output logic [DATA_W-1:0] ex_store_data_o,
  output logic [REG_AW-1:0] ex_wr_addr_o,
  output logic              ex_valid_o,
  output logic              ex_reg_write_o,
  output logic              ex_mem_read_o,
  output logic              ex_mem_write_o,
  output logic              ex_mem_to_reg_o,
  output logic              load_use_hazard_o,
  output logic [1:0]        fwd_a_o,
  output logic [1:0]        fwd_b_o
);
  logic              r_valid, r_reg_write, r_mem_read, r_mem_write, r_mem_to_reg, r_alu_src;
  logic [CTRL_W-1:0] r_ctrl;
  logic [REG_AW-1:0] r_rs_addr, r_rt_addr, r_wr_addr;
  logic [DATA_W-1:0] r_rs_data, r_rt_data, r_imm;
  logic              w_bubble, w_mem_a, w_mem_b, w_wb_a, w_wb_b;
  logic [DATA_W-1:0] w_fwd_b;
  always_comb begin
    load_use_hazard_o = r_valid & r_mem_read & (r_wr_addr != '0) & id_valid_i &
                        ((r_wr_addr == id_rs_addr_i) | (r_wr_addr == id_rt_addr_i));
    w_bubble = rst_i | flush_i | (~stall_i & load_use_hazard_o);
    w_mem_a  = r_valid & mem_reg_write_i & (mem_rd_addr_i != '0) & (mem_rd_addr_i == r_rs_addr);
    w_mem_b  = r_valid & mem_reg_write_i & (mem_rd_addr_i != '0) & (mem_rd_addr_i == r_rt_addr);
    w_wb_a   = r_valid & wb_reg_write_i & (wb_rd_addr_i != '0) & (wb_rd_addr_i == r_rs_addr);
    w_wb_b   = r_valid & wb_reg_write_i & (wb_rd_addr_i != '0) & (wb_rd_addr_i == r_rt_addr);
    fwd_a_o  = w_mem_a ? 2'b10 : w_wb_a ? 2'b01 : 2'b00;
    fwd_b_o  = w_mem_b ? 2'b10 : w_wb_b ? 2'b01 : 2'b00;
    alu_src1_o = w_mem_a ? mem_result_i : w_wb_a ? wb_result_i : r_rs_data;
    w_fwd_b    = w_mem_b ? mem_result_i : w_wb_b ? wb_result_i : r_rt_data;
    alu_src2_o = r_alu_src ? r_imm : w_fwd_b;
    ex_store_data_o = w_fwd_b;
  end
  always_ff @(posedge clk_i) begin
    if (w_bubble) begin
      r_valid      <= 1'b0;
      r_reg_write  <= 1'b0;
      r_mem_read   <= 1'b0;
      r_mem_write  <= 1'b0;
      r_mem_to_reg <= 1'b0;
      r_alu_src    <= 1'b0;
      r_ctrl       <= '0;
      r_rs_addr    <= '0;
      r_rt_addr    <= '0;
      r_wr_addr    <= '0;
      r_rs_data    <= '0;
      r_rt_data    <= '0;
      r_imm        <= '0;
    end else if (!stall_i) begin
      r_valid      <= id_valid_i;
      r_reg_write  <= id_reg_write_i;
      r_mem_read   <= id_mem_read_i;
      r_mem_write  <= id_mem_write_i;
      r_mem_to_reg <= id_mem_to_reg_i;
      r_alu_src    <= id_alu_src_i;
      r_ctrl       <= id_alu_ctrl_i;
      r_rs_addr    <= id_rs_addr_i;
      r_rt_addr    <= id_rt_addr_i;
      r_wr_addr    <= id_reg_dst_i ? id_rd_addr_i : id_rt_addr_i;
      r_rs_data    <= id_rs_data_i;
      r_rt_data    <= id_rt_data_i;
      r_imm        <= id_imm_i;
    end
  end
  assign alu_ctrl_o      = r_ctrl;
  assign ex_wr_addr_o    = r_wr_addr;
  assign ex_valid_o      = r_valid;
  assign ex_reg_write_o  = r_reg_write;
  assign ex_mem_read_o   = r_mem_read;
  assign ex_mem_write_o  = r_mem_write;
  assign ex_mem_to_reg_o = r_mem_to_reg;
endmodule

// File: tb/tb_ex_stage_reg.sv
// tb_ex_stage_reg: scoreboard bench checking ex_stage_reg against a pipeline-slot reference model
module tb_ex_stage_reg;
  logic clk_i = 1'b0;
  always #5 clk_i = ~clk_i;
  logic        rst_i, stall_i, flush_i, id_valid_i;
  logic [31:0] id_rs_data_i, id_rt_data_i, id_imm_i;
  logic [4:0]  id_rs_addr_i, id_rt_addr_i, id_rd_addr_i;
  logic [3:0]  id_alu_ctrl_i;
  logic        id_alu_src_i, id_reg_dst_i, id_reg_write_i, id_mem_read_i, id_mem_write_i, id_mem_to_reg_i;
  logic        mem_reg_write_i, wb_reg_write_i;
  logic [4:0]  mem_rd_addr_i, wb_rd_addr_i;
  logic [31:0] mem_result_i, wb_result_i;
  logic [31:0] alu_src1_o, alu_src2_o, ex_store_data_o;
  logic [3:0]  alu_ctrl_o;
  logic [4:0]  ex_wr_addr_o;
  logic        ex_valid_o, ex_reg_write_o, ex_mem_read_o, ex_mem_write_o, ex_mem_to_reg_o, load_use_hazard_o;
  logic [1:0]  fwd_a_o, fwd_b_o;
  ex_stage_reg dut (
    .clk_i(clk_i), .rst_i(rst_i), .stall_i(stall_i), .flush_i(flush_i), .id_valid_i(id_valid_i),
    .id_rs_data_i(id_rs_data_i), .id_rt_data_i(id_rt_data_i), .id_imm_i(id_imm_i),
    .id_rs_addr_i(id_rs_addr_i), .id_rt_addr_i(id_rt_addr_i), .id_rd_addr_i(id_rd_addr_i),
    .id_alu_ctrl_i(id_alu_ctrl_i), .id_alu_src_i(id_alu_src_i), .id_reg_dst_i(id_reg_dst_i),
    .id_reg_write_i(id_reg_write_i), .id_mem_read_i(id_mem_read_i), .id_mem_write_i(id_mem_write_i),
    .id_mem_to_reg_i(id_mem_to_reg_i), .mem_reg_write_i(mem_reg_write_i), .mem_rd_addr_i(mem_rd_addr_i),
    .mem_result_i(mem_result_i), .wb_reg_write_i(wb_reg_write_i), .wb_rd_addr_i(wb_rd_addr_i),
    .wb_result_i(wb_result_i), .alu_src1_o(alu_src1_o), .alu_src2_o(alu_src2_o), .alu_ctrl_o(alu_ctrl_o),
    .ex_store_data_o(ex_store_data_o), .ex_wr_addr_o(ex_wr_addr_o), .ex_valid_o(ex_valid_o),
    .ex_reg_write_o(ex_reg_write_o), .ex_mem_read_o(ex_mem_read_o), .ex_mem_write_o(ex_mem_write_o),
    .ex_mem_to_reg_o(ex_mem_to_reg_o), .load_use_hazard_o(load_use_hazard_o),
    .fwd_a_o(fwd_a_o), .fwd_b_o(fwd_b_o)
  );
  typedef struct {
    bit v, rw, mr, mw, m2r, as;
    bit [3:0] ctrl;
    bit [4:0] rs, rt, wr;
    bit [31:0] rsd, rtd, imm;
  } slot_t;
  typedef struct {
    bit [31:0] s1, s2, st;
    bit [3:0] ctrl;
    bit [4:0] wr;
    bit v, rw, mr, mw, m2r, hz;
    bit [1:0] fa, fb;
  } exp_t;
  slot_t m = '{default: 0};
  exp_t  q[$];
  int checks = 0, failures = 0;
  function automatic bit haz();
    return m.v && m.mr && m.wr != 0 && id_valid_i && (m.wr == id_rs_addr_i || m.wr == id_rt_addr_i);
  endfunction
  function automatic void fwd(input bit [4:0] a, input bit [31:0] d, output bit [1:0] s, output bit [31:0] val);
    if (m.v && mem_reg_write_i && mem_rd_addr_i != 0 && mem_rd_addr_i == a) begin s = 2'b10; val = mem_result_i; end
    else if (m.v && wb_reg_write_i && wb_rd_addr_i != 0 && wb_rd_addr_i == a) begin s = 2'b01; val = wb_result_i; end
    else begin s = 2'b00; val = d; end
  endfunction
  task automatic tick();
    @(posedge clk_i);
    if (rst_i || flush_i || (!stall_i && haz())) m = '{default: 0};
    else if (!stall_i) begin
      m.v = id_valid_i; m.rw = id_reg_write_i; m.mr = id_mem_read_i; m.mw = id_mem_write_i;
      m.m2r = id_mem_to_reg_i; m.as = id_alu_src_i; m.ctrl = id_alu_ctrl_i;
      m.rs = id_rs_addr_i; m.rt = id_rt_addr_i; m.wr = id_reg_dst_i ? id_rd_addr_i : id_rt_addr_i;
      m.rsd = id_rs_data_i; m.rtd = id_rt_data_i; m.imm = id_imm_i;
    end
    #1;
  endtask
  task automatic cyc();
    exp_t e;
    bit [31:0] b;
    fwd(m.rs, m.rsd, e.fa, e.s1);
    fwd(m.rt, m.rtd, e.fb, b);
    e.s2 = m.as ? m.imm : b; e.st = b; e.ctrl = m.ctrl; e.wr = m.wr;
    e.v = m.v; e.rw = m.rw; e.mr = m.mr; e.mw = m.mw; e.m2r = m.m2r; e.hz = haz();
    q.push_back(e);
    tick();
  endtask
  task automatic chk(input string n, input logic [31:0] a, input bit [31:0] x);
    checks++;
    if (a !== {1'b0, x}) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", n, a, x, $time);
    end
  endtask
  initial begin
    exp_t e;
    forever begin
      @(negedge clk_i);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("alu_src1", alu_src1_o, e.s1);
        chk("alu_src2", alu_src2_o, e.s2);
        chk("store_data", ex_store_data_o, e.st);
        chk("alu_ctrl", {28'd0, alu_ctrl_o}, {28'd0, e.ctrl});
        chk("wr_addr", {27'd0, ex_wr_addr_o}, {27'd0, e.wr});
        chk("ctrl_bits", {26'd0, ex_valid_o, ex_reg_write_o, ex_mem_read_o, ex_mem_write_o, ex_mem_to_reg_o, load_use_hazard_o},
            {26'd0, e.v, e.rw, e.mr, e.mw, e.m2r, e.hz});
        chk("fwd_sel", {28'd0, fwd_a_o, fwd_b_o}, {28'd0, e.fa, e.fb});
      end
    end
  end
  task automatic idle();
    rst_i = 0; stall_i = 0; flush_i = 0; id_valid_i = 0;
    id_rs_data_i = 0; id_rt_data_i = 0; id_imm_i = 0; id_rs_addr_i = 0; id_rt_addr_i = 0; id_rd_addr_i = 0;
    id_alu_ctrl_i = 0; id_alu_src_i = 0; id_reg_dst_i = 0; id_reg_write_i = 0; id_mem_read_i = 0;
    id_mem_write_i = 0; id_mem_to_reg_i = 0;
    mem_reg_write_i = 0; mem_rd_addr_i = 0; mem_result_i = 0; wb_reg_write_i = 0; wb_rd_addr_i = 0; wb_result_i = 0;
  endtask
  task automatic rand_id();
    bit [3:0] ops[5] = '{4'b0010, 4'b0110, 4'b0000, 4'b0001, 4'b0111};
    id_valid_i = ($urandom % 4) != 0;
    id_rs_data_i = $urandom; id_rt_data_i = $urandom; id_imm_i = $urandom;
    id_rs_addr_i = 5'($urandom % 8); id_rt_addr_i = 5'($urandom % 8); id_rd_addr_i = 5'($urandom % 8);
    id_alu_ctrl_i = ops[$urandom % 5];
    {id_alu_src_i, id_reg_dst_i, id_reg_write_i, id_mem_read_i, id_mem_write_i, id_mem_to_reg_i} = 6'($urandom);
  endtask
  task automatic rand_fw();
    mem_reg_write_i = 1'($urandom); mem_rd_addr_i = 5'($urandom % 8); mem_result_i = $urandom;
    wb_reg_write_i = 1'($urandom); wb_rd_addr_i = 5'($urandom % 8); wb_result_i = $urandom;
  endtask
  initial begin
    idle(); rst_i = 1; rand_id(); rand_fw();
    tick();
    rand_id(); rand_fw(); cyc();
    rand_id(); rand_fw(); cyc();
    idle(); rand_id(); id_valid_i = 1; id_mem_read_i = 0; cyc();
    idle(); cyc();
    idle(); id_valid_i = 1; id_rs_addr_i = 1; id_rt_addr_i = 2; id_rd_addr_i = 3; id_reg_dst_i = 1;
    id_rs_data_i = 5; id_rt_data_i = 7; id_alu_ctrl_i = 4'b0010; id_reg_write_i = 1; cyc();
    idle(); cyc();
    idle(); id_valid_i = 1; id_rs_addr_i = 4; id_rt_addr_i = 6; id_rs_data_i = 32'hAA; id_reg_write_i = 1; cyc();
    idle(); stall_i = 1; mem_reg_write_i = 1; mem_rd_addr_i = 4; mem_result_i = 32'h11;
    wb_reg_write_i = 1; wb_rd_addr_i = 4; wb_result_i = 32'h22; cyc();
    mem_reg_write_i = 0; cyc();
    mem_reg_write_i = 1; mem_rd_addr_i = 0; wb_rd_addr_i = 0; cyc();
    idle(); id_valid_i = 1; id_mem_read_i = 1; id_reg_write_i = 1; id_mem_to_reg_i = 1;
    id_rs_addr_i = 9; id_rt_addr_i = 8; id_alu_src_i = 1; cyc();
    idle(); id_valid_i = 1; id_rs_addr_i = 1; id_rt_addr_i = 8; id_reg_write_i = 1; cyc();
    idle(); cyc();
    idle(); id_valid_i = 1; id_mem_read_i = 1; id_rt_addr_i = 0; cyc();
    idle(); id_valid_i = 1; id_rt_addr_i = 0; id_rs_addr_i = 0; cyc();
    idle(); rand_id(); id_valid_i = 1; id_mem_read_i = 0; cyc();
    stall_i = 1;
    repeat (3) begin rand_id(); cyc(); end
    flush_i = 1; cyc();
    idle(); cyc();
    idle(); id_valid_i = 1; id_alu_src_i = 1; id_imm_i = 32'hFFFFFFFC; id_rs_addr_i = 6; id_rt_addr_i = 5;
    id_rt_data_i = 1; id_mem_write_i = 1; id_alu_ctrl_i = 4'b0010; cyc();
    idle(); wb_reg_write_i = 1; wb_rd_addr_i = 5; wb_result_i = 32'h99; cyc();
    rst_i = 1; stall_i = 1; rand_id(); cyc();
    repeat (400) begin
      rand_id(); rand_fw();
      rst_i = ($urandom % 50) == 0; stall_i = ($urandom % 5) == 0; flush_i = ($urandom % 8) == 0;
      cyc();
    end
    repeat (2) @(negedge clk_i);
    #1;
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain actual=%0d required=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/ex_stage_reg.md
Name: ex_stage_reg

Overview:
- ID/EX pipeline register and EX-stage operand selector for the 5-stage pipelined MIPS CPU.
- Captures decoded operands and control from ID.
- Applies MEM/WB forwarding and drives the ALU's two operand inputs and its 4-bit control.
- Detects load-use hazards and inserts bubbles, flushes and stalls on request.

Parameters:
DATA_W, 32, datapath width
REG_AW, 5, register address width
CTRL_W, 4, ALU control width (0010 ADD, 0110 SUB, 0000 AND, 0001 OR, 0111 SLT)

Ports:
clk_i  input  1  clock, rising edge
rst_i  input  1  synchronous reset, active high
stall_i  input  1  global pipeline freeze; EX register holds
flush_i  input  1  replace next EX contents with bubble (branch taken)
id_valid_i  input  1  ID holds a real instruction
id_rs_data_i  input  DATA_W  register-file rs value
id_rt_data_i  input  DATA_W  register-file rt value
id_imm_i  input  DATA_W  sign-extended immediate
id_rs_addr_i  input  REG_AW  rs index
id_rt_addr_i  input  REG_AW  rt index
id_rd_addr_i  input  REG_AW  rd index
id_alu_ctrl_i  input  CTRL_W  ALU operation
id_alu_src_i  input  1  1 = ALU operand 2 is the immediate
id_reg_dst_i  input  1  1 = destination is rd, 0 = destination is rt
id_reg_write_i, id_mem_read_i, id_mem_write_i, id_mem_to_reg_i  input  1 each  downstream control
mem_reg_write_i  input  1  EX/MEM instruction writes a register
mem_rd_addr_i  input  REG_AW  EX/MEM destination
mem_result_i  input  DATA_W  EX/MEM ALU result
wb_reg_write_i  input  1  MEM/WB instruction writes a register
wb_rd_addr_i  input  REG_AW  MEM/WB destination
wb_result_i  input  DATA_W  MEM/WB write-back value
alu_src1_o  output  DATA_W  ALU src1
alu_src2_o  output  DATA_W  ALU src2
alu_ctrl_o  output  CTRL_W  ALU ctrl
ex_store_data_o  output  DATA_W  forwarded rt, for SW
ex_wr_addr_o  output  REG_AW  selected destination register
ex_valid_o, ex_reg_write_o, ex_mem_read_o, ex_mem_write_o, ex_mem_to_reg_o  output  1 each  registered control
load_use_hazard_o  output  1  ID must hold (combinational)
fwd_a_o, fwd_b_o  output  2 each  forward selects: 00 reg, 10 MEM, 01 WB

Behaviour:
- Reset (rst_i=1 at edge): all EX registers cleared to 0, so valid, controls, addresses, data and ctrl are all 0. With forwarding off, alu_src1_o, alu_src2_o and ex_store_data_o read 0.
- Register update priority each edge: rst_i > flush_i > stall_i > load_use_hazard_o > load.
  - flush: bubble (valid and all control bits 0, data don't-care but cleared to 0).
  - stall: hold all state.
  - hazard: bubble.
  - load: capture all id_* fields; valid = id_valid_i.
- Flush during stall: bubble wins.
- Reset mid-stall: reset wins.
- load_use_hazard_o = ex_valid & ex_mem_read & ex_wr_addr != 0 & id_valid_i & (ex_wr_addr == id_rs_addr_i | ex_wr_addr == id_rt_addr_i). Asserted regardless of stall_i.
- ex_wr_addr captured as id_reg_dst_i ? rd : rt.
- Forwarding is combinational from the registered rs/rt address and data. Shown for A; B is identical using rt.
  - MEM match = mem_reg_write_i & mem_rd_addr_i != 0 & mem_rd_addr_i == rs → fwd_a=10, value mem_result_i.
  - Else WB match, same rule → fwd_a=01, value wb_result_i.
  - Else 00, value the registered rs data.
  - MEM has priority when both match.
  - Register 0 is never forwarded.
  - Forward selects are forced to 00 when ex_valid=0.
- alu_src1_o = forwarded A.
- alu_src2_o = ex_alu_src ? registered imm : forwarded B.
- ex_store_data_o = forwarded B, independent of alu_src.
- alu_ctrl_o = registered ctrl; a bubble yields 0000 (AND), which is harmless because all write/mem enables are 0.
- Latency: one cycle from ID capture to EX outputs. Outputs are stable for the whole EX cycle except the forwarding inputs' combinational paths.
- stall_i freezes the entire pipeline, so forwarding sources stay consistent while held.

Test Plan:
- Reset: hold rst_i 2 cycles with random id_* inputs → all outputs 0, fwd_a/b=00; first clean edge loads id values.
- ADD r3=r1+r2 (rs=1, rt=2, rd=3, reg_dst=1, data 5/7, ctrl 0010) → next cycle src1=5, src2=7, wr_addr=3, reg_write=1.
- Forward priority: EX holds rs=4; mem_rd=4 result 0x11; wb_rd=4 result 0x22 → src1=0x11, fwd_a=10. Drop MEM → src1=0x22, fwd_a=01. Set rd=0 on both → no forward.
- Load-use: EX is LW with wr_addr=8; ID has rt=8, valid=1 → hazard=1 and next edge loads a bubble (valid 0, all enables 0). With wr_addr=0 → no hazard.
- Stall then flush: stall_i=1 for 3 cycles → outputs unchanged. Assert flush_i together with stall_i → bubble on that edge.
- SW with alu_src=1, imm=0xFFFFFFFC, rt forwarded from WB value 0x99 → src2=0xFFFFFFFC, ex_store_data_o=0x99.
